// File: rtl/spi_encoder.sv
// spi_encoder: SPI mode-0 frame transmitter sending {code, data} MSB first; define SPI_ENCODER_PARITY_EN to append an odd-parity bit
module spi_encoder #(
    parameter int unsigned CLK_DIV   = 2,
    parameter logic [7:0]  ROLL_CODE = 8'h41
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_code,
    input  logic [7:0] cmd_data,
    input  logic       roll_req,
    output logic       sclk,
    output logic       mosi,
    output logic       cs_n,
    output logic       busy,
    output logic       done
);
`ifdef SPI_ENCODER_PARITY_EN
    localparam int FB = 17;
`else
    localparam int FB = 16;
`endif
    localparam logic [7:0] DIV_LD = 8'(CLK_DIV - 1);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
    state_t        state_q, state_d;
    logic [7:0]    div_q, div_d;
    logic [4:0]    bit_q, bit_d;
    logic [FB-1:0] sr_q, sr_d, load;
    logic          sclk_q, sclk_d, en_q;
    logic [15:0]   frame;
    logic          accept, tick;
    assign frame = {roll_req ? ROLL_CODE : cmd_code, cmd_data};
`ifdef SPI_ENCODER_PARITY_EN
    assign load = {frame, ~^frame};
`else
    assign load = frame;
`endif
    assign cmd_ready = en_q && state_q == IDLE;
    assign accept    = cmd_valid && cmd_ready;
    assign tick      = div_q == 8'd0;
    assign busy      = state_q != IDLE;
    assign cs_n      = state_q == IDLE || state_q == GAP;
    assign sclk      = sclk_q;
    assign mosi      = !cs_n && sr_q[FB-1];
    assign done      = state_q == GAP && div_q == DIV_LD;
    // next state: each phase lasts CLK_DIV cycles; data shifts only when sclk falls, never after the last bit
    always_comb begin
        state_d = state_q;
        div_d   = tick ? DIV_LD : div_q - 8'd1;
        bit_d   = bit_q;
        sr_d    = sr_q;
        sclk_d  = sclk_q;
        case (state_q)
            IDLE: begin
                div_d  = DIV_LD;
                bit_d  = 5'd0;
                sclk_d = 1'b0;
                if (accept) begin
                    state_d = SETUP;
                    sr_d    = load;
                end
            end
            SETUP: if (tick) begin
                state_d = SHIFT;
                sclk_d  = 1'b1;
                bit_d   = 5'd0;
            end
            SHIFT: if (tick) begin
                sclk_d = !sclk_q;
                if (sclk_q) begin
                    if (bit_q == 5'(FB - 1)) state_d = HOLD;
                    else begin
                        sr_d  = sr_q << 1;
                        bit_d = bit_q + 5'd1;
                    end
                end
            end
            HOLD:    if (tick) state_d = GAP;
            GAP:     if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // state registers; reset aborts any frame immediately and holds cmd_ready low until the first edge after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= 8'd0;
            bit_q   <= 5'd0;
            sr_q    <= '0;
            sclk_q  <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            sclk_q  <= sclk_d;
            en_q    <= 1'b1;
        end
    end
endmodule

// File: tb/tb_spi_encoder.sv
// tb_spi_encoder: directed vector bench for spi_encoder at CLK_DIV=2 and CLK_DIV=1
module tb_spi_encoder;
`ifdef SPI_ENCODER_PARITY_EN
    localparam int FB = 17;
`else
    localparam int FB = 16;
`endif
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;
    logic va = 0, ra, rolla = 0, sa, ma, ca, ba, da;
    logic vb = 0, rb, rollb = 0, sb, mb, cb, bb, db;
    logic [7:0] codea = 0, dataa = 0, codeb = 0, datab = 0;
    spi_encoder #(.CLK_DIV(2)) dut_a (.clk(clk), .rst_n(rst_n), .cmd_valid(va), .cmd_ready(ra),
        .cmd_code(codea), .cmd_data(dataa), .roll_req(rolla), .sclk(sa), .mosi(ma), .cs_n(ca),
        .busy(ba), .done(da));
    spi_encoder #(.CLK_DIV(1)) dut_b (.clk(clk), .rst_n(rst_n), .cmd_valid(vb), .cmd_ready(rb),
        .cmd_code(codeb), .cmd_data(datab), .roll_req(rollb), .sclk(sb), .mosi(mb), .cs_n(cb),
        .busy(bb), .done(db));
    logic [31:0] cap_a = 0, cap_b = 0;
    logic ps_a = 0, ps_b = 0;
    int nb_a = 0, run_a = 0, len_a = 0, dn_a = 0;
    int nb_b = 0, run_b = 0, len_b = 0, dn_b = 0, hi_b = 0, hil_b = 0;
    always @(negedge clk) begin
        ps_a <= sa;
        if (sa && !ps_a) begin cap_a <= {cap_a[30:0], ma}; nb_a <= nb_a + 1; end
        run_a <= ca ? 0 : run_a + 1;
        if (ca && run_a != 0) len_a <= run_a;
        if (da) dn_a <= dn_a + 1;
        ps_b <= sb;
        if (sb && !ps_b) begin cap_b <= {cap_b[30:0], mb}; nb_b <= nb_b + 1; end
        run_b <= cb ? 0 : run_b + 1;
        if (cb && run_b != 0) len_b <= run_b;
        hi_b <= cb ? hi_b + 1 : 0;
        if (!cb && hi_b != 0) hil_b <= hi_b;
        if (db) dn_b <= dn_b + 1;
    end
    int checks = 0, errors = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    function automatic logic [FB-1:0] fr(input logic [15:0] f);
`ifdef SPI_ENCODER_PARITY_EN
        return {f, ~^f};
`else
        return f;
`endif
    endfunction
    task automatic send_a(input logic [7:0] c, input logic [7:0] d, input logic r);
        int n;
        @(posedge clk); #1 codea = c; dataa = d; rolla = r; va = 1;
        @(posedge clk); #1 va = 0; codea = ~c; dataa = ~d; rolla = ~r;
        @(negedge clk);
        chk("busy in frame", ba, 1);
        chk("ready in frame", ra, 0);
        n = 0;
        while (!da && n < 300) begin @(negedge clk); n++; end
        chk("done seen", da, 1);
        repeat (4) @(negedge clk);
    endtask
    typedef struct { logic [7:0] code; logic [7:0] data; logic roll; logic [15:0] exp; } vec_t;
    vec_t vt[6];
    initial begin
        int nb0, dn0, n, k;
        logic pl;
        vt[0] = '{8'hA5, 8'h3C, 1'b0, 16'hA53C};
        vt[1] = '{8'hFF, 8'h07, 1'b1, 16'h4107};
        vt[2] = '{8'h00, 8'h00, 1'b0, 16'h0000};
        vt[3] = '{8'hFF, 8'hFF, 1'b0, 16'hFFFF};
        vt[4] = '{8'h12, 8'h80, 1'b0, 16'h1280};
        vt[5] = '{8'h41, 8'h00, 1'b0, 16'h4100};
        #12;
        chk("rst cs_n", ca, 1); chk("rst sclk", sa, 0); chk("rst mosi", ma, 0);
        chk("rst ready", ra, 0); chk("rst busy", ba, 0); chk("rst done", da, 0);
        chk("rst ready b", rb, 0);
        @(negedge clk); rst_n = 1; #1;
        chk("ready before edge", ra, 0);
        @(posedge clk); #1;
        chk("ready after edge", ra, 1); chk("ready after edge b", rb, 1);
        for (int i = 0; i < 6; i++) begin
            nb0 = nb_a; dn0 = dn_a;
            send_a(vt[i].code, vt[i].data, vt[i].roll);
            chk("bit count", nb_a - nb0, FB);
            chk("frame bits", cap_a[FB-1:0], fr(vt[i].exp));
            chk("cs_n low len", len_a, (2 * FB + 1) * 2);
            chk("done pulses", dn_a - dn0, 1);
            chk("idle cs_n", ca, 1); chk("idle sclk", sa, 0); chk("idle mosi", ma, 0); chk("idle busy", ba, 0);
        end
        @(negedge clk); codeb = 8'h5A; datab = 8'hC3; rollb = 0; vb = 1;
        n = 0;
        while (!db && n < 300) begin @(negedge clk); n++; end
        chk("b2b first done", db, 1);
        n = 0;
        while (cb && n < 20) begin @(negedge clk); n++; end
        chk("b2b second start", cb, 0);
        codeb = 8'h00; datab = 8'h00; rollb = 1;
        n = 0;
        while (!db && n < 300) begin @(negedge clk); n++; end
        chk("b2b second done", db, 1);
        vb = 0;
        repeat (6) @(negedge clk);
        chk("b2b frame2 bits", cap_b[FB-1:0], fr(16'h5AC3));
        chk("b2b bit count", nb_b, 2 * FB);
        chk("b2b cs_n low len", len_b, 2 * FB + 1);
        chk("b2b cs_n high gap", hil_b, 2);
        chk("b2b done pulses", dn_b, 2);
        chk("b2b stopped", cb, 1);
        nb0 = nb_a; dn0 = dn_a;
        @(posedge clk); #1 codea = 8'hC3; dataa = 8'h99; rolla = 0; va = 1;
        @(posedge clk); #1 va = 0;
        k = 0; n = 0; pl = sa;
        while (k < 10 && n < 300) begin
            @(negedge clk); n++;
            if (sa && !pl) k++;
            pl = sa;
        end
        chk("tenth edge reached", k, 10);
        chk("sclk high before abort", sa, 1);
        rst_n = 0; #1;
        chk("abort cs_n", ca, 1); chk("abort sclk", sa, 0); chk("abort mosi", ma, 0);
        chk("abort busy", ba, 0); chk("abort done", da, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (3) @(negedge clk);
        chk("abort no done", dn_a - dn0, 0);
        chk("abort bit count", nb_a - nb0, 10);
        nb0 = nb_a; dn0 = dn_a;
        send_a(8'h3C, 8'hA5, 1'b0);
        chk("post abort bits", cap_a[FB-1:0], fr(16'h3CA5));
        chk("post abort count", nb_a - nb0, FB);
        chk("post abort cs len", len_a, (2 * FB + 1) * 2);
        chk("post abort done", dn_a - dn0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
